// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises external interrupt lines, latches pending requests,
// applies enable mask and fixed lowest-index-first priority, and drives a
// single registered request into the control unit with ack/EOI handshake.
module irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               irq_ack,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [31:0]        wr_data,
    output logic [31:0]        rd_data,
    output logic               irq,
    output logic [4:0]         irq_id
);

    // Bits at and above NUM_IRQ are held at zero throughout; keeping every
    // register 32 wide lets reads return the value directly.
    localparam logic [31:0] IRQ_MASK = (NUM_IRQ >= 32) ? 32'hFFFF_FFFF
                                                       : ((32'd1 << NUM_IRQ) - 32'd1);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_VECTOR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sync1_q, sync1_d;
    logic [31:0] sync2_q, sync2_d;
    logic [31:0] prev_q, prev_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] enable_q, enable_d;
    logic [31:0] edge_mode_q, edge_mode_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        irq_q, irq_d;
    logic [4:0]  irq_id_q, irq_id_d;

    logic [31:0] irq_ext;
    logic [31:0] wr_bits;
    logic [31:0] cand;
    logic [31:0] rise;
    logic [31:0] clr;
    logic [4:0]  win_id;
    logic        win_found;
    logic        wr_pending, wr_enable, wr_edge, wr_eoi;
    logic        ack_take;

    assign irq_ext = 32'(irq_in);
    assign rd_data = rd_data_q;
    assign irq     = irq_q;
    assign irq_id  = irq_id_q;

    // Register-window decode and masked write data.
    always_comb begin
        wr_pending = wr_en && (addr == ADDR_PENDING);
        wr_enable  = wr_en && (addr == ADDR_ENABLE);
        wr_edge    = wr_en && (addr == ADDR_EDGE);
        wr_eoi     = wr_en && (addr == ADDR_VECTOR);
        wr_bits    = wr_data & IRQ_MASK;
    end

    // Fixed priority: lowest enabled pending index wins.
    always_comb begin
        cand      = pending_q & enable_q;
        win_id    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (cand[i] && !win_found) begin
                win_id    = 5'(i);
                win_found = 1'b1;
            end
        end
    end

    // Request FSM next state; irq is registered from the next state so it
    // changes on the same edge as the state.
    always_comb begin
        state_d  = state_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!win_found) begin
                    state_d = ST_IDLE;
                end else if (irq_ack) begin
                    state_d  = ST_SERVICE;
                    ack_take = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d    = (state_d == ST_REQ);
        irq_id_d = ack_take ? win_id : irq_id_q;
    end

    // Synchroniser, edge detect and pending/enable/edge register updates.
    always_comb begin
        sync1_d = irq_ext & IRQ_MASK;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;

        clr = '0;
        if (wr_pending) clr = wr_bits;
        if (ack_take)   clr = clr | (32'd1 << win_id);
        clr = clr & edge_mode_q;

        // Edge-mode bits: set dominates clear. Level-mode bits mirror sync2.
        pending_d = (edge_mode_q & ((pending_q & ~clr) | rise))
                  | (~edge_mode_q & sync2_q);

        enable_d    = wr_enable ? wr_bits : enable_q;
        edge_mode_d = wr_edge   ? wr_bits : edge_mode_q;
    end

    // Registered read port; reads see pre-write register values.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (addr)
                ADDR_PENDING: rd_data_d = pending_q;
                ADDR_ENABLE:  rd_data_d = enable_q;
                ADDR_EDGE:    rd_data_d = edge_mode_q;
                default:      rd_data_d = (state_q == ST_SERVICE) ? {27'b0, irq_id_q} : '0;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= '0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
        end
    end

endmodule
